// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core slice.
// LSU state encoding, access sizes, AXI response codes, memory map.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        RESP
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1000_0000;

    // Address not a multiple of the access size.
    function automatic logic lsu_misaligned(
        input logic [2:0] a,
        input logic [1:0] sz
    );
        logic r;
        unique case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = a[0];
            SZ_WORD: r = |a[1:0];
            default: r = |a[2:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-lite bundle with all five channels.
// Master drives addresses, write data and the response readies.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: byte-lane steering between core and bus.
// Shifts store data into lanes, builds wstrb, extends load data.
import mips_pkg::*;

module mips_lsu_align #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [OFF_W-1:0]    i_off,
    input  logic [1:0]          i_size,
    input  logic                i_signed,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W-1:0]   i_rdata,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic [DATA_W-1:0]   o_rdata
);
    localparam int STRB_W = DATA_W/8;

    logic [STRB_W-1:0] w_bmask;
    logic [DATA_W-1:0] w_dmask;
    logic [DATA_W-1:0] w_shift;
    logic              w_sbit;

    // Lane masks and sign bit for the access size.
    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        unique case (i_size)
            SZ_BYTE: begin
                w_bmask = STRB_W'(1);
                w_dmask = DATA_W'(8'hFF);
                w_sbit  = w_shift[7];
            end
            SZ_HALF: begin
                w_bmask = STRB_W'(3);
                w_dmask = DATA_W'(16'hFFFF);
                w_sbit  = w_shift[15];
            end
            SZ_WORD: begin
                w_bmask = STRB_W'(15);
                w_dmask = DATA_W'(32'hFFFF_FFFF);
                w_sbit  = w_shift[31];
            end
            default: begin
                w_bmask = '1;
                w_dmask = '1;
                w_sbit  = w_shift[DATA_W-1];
            end
        endcase
    end

    // Steer store data/strobes and extend load data.
    always_comb begin
        o_wdata = i_wdata << {i_off, 3'b000};
        o_wstrb = w_bmask << i_off;
        o_rdata = (w_shift & w_dmask) |
                  ((i_signed && w_sbit) ? ~w_dmask : '0);
    end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding load/store unit, AXI-lite master.
// Accepts one core request, runs one bus transaction, pulses rsp.
import mips_pkg::*;

module mips_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    axi_lite_if.master        m_if
);
    localparam int OFF_W  = $clog2(DATA_W/8);
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;
    localparam int STRB_W = DATA_W/8;

    lsu_state_t        r_state;
    lsu_state_t        w_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_aw_done;
    logic              r_w_done;
    logic              w_aw_done;
    logic              w_w_done;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_accept;
    logic              w_bad;
    logic              w_tmo;
    logic              w_cnt_max;
    logic [DATA_W-1:0] w_st_data;
    logic [STRB_W-1:0] w_st_strb;
    logic [DATA_W-1:0] w_ld_data;

    assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT-1));

    assign w_bad = lsu_misaligned(req_addr[2:0], req_size) ||
                   (req_size == SZ_DWORD && DATA_W == 32);

    mips_lsu_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .i_off    (r_addr[OFF_W-1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .i_rdata  (m_if.rdata),
        .o_wdata  (w_st_data),
        .o_wstrb  (w_st_strb),
        .o_rdata  (w_ld_data)
    );

    // State, per-channel write progress and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
            if (w_nxt != r_state)
                r_cnt <= '0;
            else if (r_state != IDLE)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next state; a handshake wins over an expiring timeout.
    always_comb begin
        w_nxt     = r_state;
        w_aw_done = r_aw_done;
        w_w_done  = r_w_done;
        w_accept  = 1'b0;
        w_tmo     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept  = 1'b1;
                    w_aw_done = 1'b0;
                    w_w_done  = 1'b0;
                    if (w_bad)
                        w_nxt = RESP;
                    else if (req_we)
                        w_nxt = WR;
                    else
                        w_nxt = RD_A;
                end
            end
            RD_A: begin
                if (m_if.arready)
                    w_nxt = RD_D;
                else if (w_cnt_max)
                    w_tmo = 1'b1;
            end
            RD_D: begin
                if (m_if.rvalid)
                    w_nxt = RESP;
                else if (w_cnt_max)
                    w_tmo = 1'b1;
            end
            WR: begin
                w_aw_done = r_aw_done | m_if.awready;
                w_w_done  = r_w_done | m_if.wready;
                if (w_aw_done && w_w_done)
                    w_nxt = WR_B;
                else if (w_cnt_max)
                    w_tmo = 1'b1;
            end
            WR_B: begin
                if (m_if.bvalid)
                    w_nxt = RESP;
                else if (w_cnt_max)
                    w_tmo = 1'b1;
            end
            RESP: w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        if (w_tmo)
            w_nxt = RESP;
    end

    // Request capture and response data/error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
                r_rdata  <= '0;
                r_err    <= w_bad;
            end
            if (r_state == RD_D && m_if.rvalid) begin
                r_rdata <= w_ld_data;
                r_err   <= (m_if.rresp != AXI_OKAY);
            end
            if (r_state == WR_B && m_if.bvalid)
                r_err <= (m_if.bresp != AXI_OKAY);
            if (w_tmo)
                r_err <= 1'b1;
        end
    end

    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign m_if.araddr  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign m_if.awaddr  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign m_if.arprot  = 3'b000;
    assign m_if.awprot  = 3'b000;
    assign m_if.arvalid = (r_state == RD_A);
    assign m_if.rready  = (r_state == RD_D);
    assign m_if.awvalid = (r_state == WR) && !r_aw_done;
    assign m_if.wvalid  = (r_state == WR) && !r_w_done;
    assign m_if.wdata   = w_st_data;
    assign m_if.wstrb   = w_st_strb;
    assign m_if.bready  = (r_state == WR_B);

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: random and directed transactions against a
// reactive AXI-lite slave and a byte-level reference model.
module tb_mips_lsu;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] g_rdata;
    logic        g_err;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    mips_lsu #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_if       (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(
        input logic [31:0] word, input int off,
        input int nb, input bit sgn);
        longint v;
        longint full;
        full = longint'(1) << (8*nb);
        v = (longint'({32'b0, word}) >> (8*off)) % full;
        if (sgn && v >= full/2)
            v = v - full;
        return v[31:0];
    endfunction

    task automatic slave_idle();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
    endtask

    task automatic txn(
        input bit we, input logic [1:0] sz,
        input bit sgn, input logic [31:0] addr,
        input logic [31:0] wd,
        input int ard, input int rd,
        input int awd, input int wdl, input int bd,
        input logic [31:0] rword, input logic [1:0] resp);
        int nb, off, lat, p, cyc;
        bit bad, tmo, seen, r_pend, b_pend;
        int ar_c, aw_c, w_c, r_w, b_w;
        int ar_b, r_b, aw_b, w_b, b_b;
        logic [31:0] ew, em;
        logic [3:0]  es;
        nb  = 1 << sz;
        off = int'(addr % 4);
        bad = (sz == 2'd3) || (addr % nb != 0);
        tmo = 1'b0;
        ew = '0; em = '0; es = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nb) begin
                es[i] = 1'b1;
                ew[8*i +: 8] = wd[8*(i-off) +: 8];
                em[8*i +: 8] = 8'hFF;
            end
        if (bad)
            lat = 1;
        else if (!we) begin
            if (ard + 1 > TO) begin
                tmo = 1'b1; lat = TO + 1;
            end else if (rd + 1 > TO) begin
                tmo = 1'b1; lat = ard + 2 + TO;
            end else
                lat = ard + rd + 3;
        end else begin
            p = ((awd > wdl) ? awd : wdl) + 1;
            if (p > TO) begin
                tmo = 1'b1; lat = TO + 1;
            end else if (bd + 1 > TO) begin
                tmo = 1'b1; lat = p + TO + 1;
            end else
                lat = p + bd + 2;
        end
        ar_c = 0; aw_c = 0; w_c = 0; r_w = 0; b_w = 0;
        ar_b = 0; r_b = 0; aw_b = 0; w_b = 0; b_b = 0;
        r_pend = 0; b_pend = 0; seen = 0;
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        cyc = 1;
        while (!seen && cyc <= 400) begin
            if (rsp_valid) begin
                seen = 1'b1;
                g_rdata = rsp_rdata;
                g_err   = rsp_err;
                chk("latency", cyc, lat);
                chk("rsp_err", rsp_err,
                    bad || tmo || (resp != 2'b00));
                if (!we && !bad && !tmo)
                    chk("rsp_rdata", rsp_rdata,
                        ld_model(rword, off, nb, sgn));
            end else begin
                axi.rvalid = r_pend && (r_w >= rd);
                if (r_pend && !axi.rvalid) r_w++;
                axi.rdata = rword;
                axi.rresp = resp;
                if (axi.rvalid && axi.rready) begin
                    r_b++; r_pend = 0;
                end
                axi.bvalid = b_pend && (b_w >= bd);
                if (b_pend && !axi.bvalid) b_w++;
                axi.bresp = resp;
                if (axi.bvalid && axi.bready) begin
                    b_b++; b_pend = 0;
                end
                axi.arready = axi.arvalid && (ar_c >= ard);
                if (axi.arvalid) begin
                    ar_c++;
                    chk("araddr", axi.araddr, addr & ~32'h3);
                    chk("arprot", axi.arprot, 0);
                end
                if (axi.arvalid && axi.arready) begin
                    ar_b++; r_pend = 1;
                end
                axi.awready = axi.awvalid && (aw_c >= awd);
                if (axi.awvalid) begin
                    aw_c++;
                    chk("awaddr", axi.awaddr, addr & ~32'h3);
                    chk("awprot", axi.awprot, 0);
                end
                axi.wready = axi.wvalid && (w_c >= wdl);
                if (axi.wvalid) begin
                    w_c++;
                    chk("wstrb", axi.wstrb, es);
                    chk("wdata", axi.wdata & em, ew);
                end
                if (axi.awvalid && axi.awready) aw_b++;
                if (axi.wvalid && axi.wready) w_b++;
                if (aw_b > 0 && w_b > 0 && b_b == 0)
                    b_pend = 1;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen)
            chk("rsp_seen", 0, 1);
        if (bad)
            chk("no_bus", ar_c + aw_c + w_c, 0);
        else if (!tmo && !we) begin
            chk("ar_beats", ar_b, 1);
            chk("r_beats", r_b, 1);
            chk("ar_cycles", ar_c, ard + 1);
            chk("wr_cycles", aw_c + w_c, 0);
        end else if (!tmo) begin
            chk("aw_beats", aw_b, 1);
            chk("w_beats", w_b, 1);
            chk("b_beats", b_b, 1);
            chk("aw_cycles", aw_c, awd + 1);
            chk("w_cycles", w_c, wdl + 1);
            chk("rd_cycles", ar_c, 0);
        end
        slave_idle();
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("back_idle", req_ready, 1);
    endtask

    initial begin
        int k;
        bit any;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        axi.rdata = '0; axi.rresp = 2'b00;
        axi.bresp = 2'b00;
        slave_idle();
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        rst = 1'b0;

        txn(0, 2'd0, 1, 32'h1000_0003, 0,
            0, 0, 0, 0, 0, 32'h80AB_CDEF, 2'b00);
        chk("lb_signed_val", g_rdata, 32'hFFFF_FF80);
        chk("lb_signed_err", g_err, 0);
        txn(1, 2'd1, 0, 32'h1000_0002, 32'h1234,
            0, 0, 0, 0, 0, 0, 2'b00);
        txn(1, 2'd2, 0, 32'h1000_0010, 32'hCAFE_F00D,
            0, 0, 3, 0, 0, 0, 2'b00);
        txn(1, 2'd0, 0, 32'h1000_0011, 32'h5A,
            0, 0, 0, 2, 1, 0, 2'b00);
        txn(0, 2'd2, 0, 32'h1000_0001, 0,
            0, 0, 0, 0, 0, 32'h1111_1111, 2'b00);
        chk("misal_err", g_err, 1);
        txn(0, 2'd3, 0, 32'h1000_0008, 0,
            0, 0, 0, 0, 0, 32'h1111_1111, 2'b00);
        txn(1, 2'd1, 0, 32'h1000_0005, 32'hBEEF,
            0, 0, 0, 0, 0, 0, 2'b00);
        txn(1, 2'd2, 0, 32'h1000_0020, 32'h0BAD_0BAD,
            0, 0, 0, 0, 0, 0, 2'b10);
        chk("slverr_err", g_err, 1);
        txn(0, 2'd1, 1, 32'h1000_0002, 0,
            0, 0, 0, 0, 0, 32'h9ABC_1234, 2'b11);
        chk("decerr_rdata", g_rdata, 32'hFFFF_9ABC);
        txn(0, 2'd2, 0, 32'h1000_0040, 0,
            100, 0, 0, 0, 0, 32'h1, 2'b00);
        chk("ar_tmo_err", g_err, 1);
        txn(1, 2'd2, 0, 32'h1000_0044, 32'h7,
            0, 0, 0, 0, 100, 0, 2'b00);
        txn(0, 2'd2, 0, 32'h1000_0048, 0,
            0, TO - 1, 0, 0, 0, 32'h7777_0001, 2'b00);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] rsp;
            rsp = ($urandom_range(3) == 0) ?
                  2'($urandom_range(1, 3)) : 2'b00;
            txn(1'($urandom), 2'($urandom),
                1'($urandom),
                32'h1000_0000 + 32'($urandom_range(255)),
                $urandom,
                $urandom_range(3), $urandom_range(3),
                $urandom_range(3), $urandom_range(3),
                $urandom_range(3), $urandom, rsp);
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0;
        req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h1000_0100;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!axi.rready && k < 20) begin
            axi.arready = axi.arvalid;
            @(negedge clk);
            k++;
        end
        axi.arready = 1'b0;
        chk("rst_mid_rd_d", axi.rready, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rready", axi.rready, 0);
        chk("rst_mid_arvalid", axi.arvalid, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        rst = 1'b0;
        any = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || axi.rready) any = 1'b1;
        end
        chk("rst_mid_quiet", any, 0);
        chk("rst_mid_idle", req_ready, 1);
        txn(0, 2'd0, 0, 32'h1000_0101, 0,
            0, 0, 0, 0, 0, 32'hA5C3_F00F, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "simulation bound exceeded");
    end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of requests and of the AXI-lite port.
REQ-002 Parameter DATA_W, default 32, bus data width; legal values 32 and 64.
REQ-003 Parameter TIMEOUT, default 256, maximum cycles spent waiting in any bus state.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid / req_ready  in / out  1  core request handshake.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64).
REQ-009 req_signed  in  1  sign-extend load data.
REQ-010 req_addr  in  ADDR_W  byte address; req_wdata  in  DATA_W  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  DATA_W  extended load data; rsp_err  out  1  error flag.
REQ-012 m_if  axi_lite master port  full AW/W/B/AR/R channels; awprot = arprot = 3'b000.

Function
REQ-013 FSM states: IDLE, RD_A, RD_D, WR, WR_B, RESP.
REQ-014 req_ready = 1 only in IDLE; a request is accepted on the cycle where req_valid and req_ready are both 1.
REQ-015 Misaligned request (address not a multiple of the size) or illegal size -> RESP with rsp_err = 1; no bus transaction issued.
REQ-016 Aligned load: IDLE -> RD_A, with arvalid = 1 and araddr = req_addr with the low log2(DATA_W/8) bits cleared.
REQ-017 RD_A -> RD_D on arready; rready = 1 in RD_D; RD_D -> RESP on rvalid.
REQ-018 Load data: select lanes by addr offset, then zero- or sign-extend per req_signed to DATA_W.
REQ-019 Aligned store: IDLE -> WR; awvalid and wvalid are asserted together.
REQ-020 In WR, each of awvalid and wvalid drops independently after its own handshake; WR -> WR_B when both handshakes are done, including the same-cycle case.
REQ-021 wdata = store data replicated or shifted into its lanes; wstrb has ones only on the addressed bytes.
REQ-022 bready = 1 in WR_B; WR_B -> RESP on bvalid.
REQ-023 rresp or bresp not equal to OKAY -> rsp_err = 1; rsp_rdata is still driven with the extended data.
REQ-024 RESP lasts exactly one cycle: rsp_valid = 1, then return to IDLE.
REQ-025 Timeout counter clears on every state change; reaching TIMEOUT-1 in RD_A, RD_D, WR or WR_B forces RESP with rsp_err = 1.
REQ-026 Request address, size, signed and data fields are latched at acceptance; later changes on req_* have no effect.
REQ-027 Best-case latency from acceptance to rsp_valid: load 3 cycles, store 3 cycles, misaligned 1 cycle.

Reset
REQ-028 With rst = 1 at a clock edge: state = IDLE, timeout counter = 0, all valid/ready outputs 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 Reset mid-transaction abandons the transaction: no rsp_valid is produced and the channels are deasserted on the next cycle.

Structure
REQ-030 Shared package mips_pkg holds the lsu_state_t enum, size encodings, AXI resp codes (OKAY = 2'b00) and the text/data base-address constants.
REQ-031 Sub-module mips_lsu_align holds the combinational lane shift, wstrb generation and load extension.

Verification
REQ-032 Load byte, signed, addr 0x1000_0003, rdata 0x80xx_xxxx, OKAY -> rsp_rdata = 0xFFFF_FF80, rsp_err = 0, araddr = 0x1000_0000.
REQ-033 Store half, addr 0x1000_0002, wdata 0x1234 -> wstrb = 4'b1100, wdata[31:16] = 0x1234, one rsp_valid after bvalid.
REQ-034 Store with awready delayed 3 cycles and wready given immediately -> wvalid drops after 1 cycle, awvalid holds 4 cycles, exactly one AW and one W beat.
REQ-035 Load word at addr 0x1000_0001 -> rsp_valid 1 cycle after acceptance, rsp_err = 1, arvalid never asserted.
REQ-036 bresp = SLVERR -> rsp_err = 1; arready held at 0 for TIMEOUT cycles -> rsp_err = 1 and return to IDLE.
REQ-037 rst asserted while in RD_D -> next cycle state IDLE, rready = 0, no rsp_valid.
